// File: rtl/z80_mem_arbiter_if.sv
// Bus bundle between the Z80 memory arbiter, its two requesters and the memory array.
// The master view is the arbiter; the slave view is everything around it.
interface z80_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_done;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_done;

  logic              MREQ_L;
  logic              RD_L;
  logic              WR_L;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wdata_oe;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;
  logic              gnt_dma;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_done,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_rdata, dma_done,
    output MREQ_L, RD_L, WR_L, mem_addr, mem_wdata, mem_wdata_oe,
    input  mem_rdata,
    output busy, gnt_dma
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_done,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_rdata, dma_done,
    input  MREQ_L, RD_L, WR_L, mem_addr, mem_wdata, mem_wdata_oe,
    output mem_rdata,
    input  busy, gnt_dma
  );
endinterface

// File: rtl/z80_mem_arbiter.sv
// Shares one Z80 memory port between CPU and DMA with round-robin grant and a fixed
// ADDR / ACCESS(+wait) / FINISH bus cycle. Outputs are registered from the next state.
module z80_mem_arbiter #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input logic               clk,
  input logic               rst,
  z80_mem_arbiter_if.master bus
);
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, ADDR, ACCESS, FINISH} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              own_we_q, own_we_d;
  logic              gnt_dma_q, gnt_dma_d;
  logic              last_dma_q, last_dma_d;
  logic              mreq_q, mreq_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              oe_q, oe_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
  logic              cpu_done_q, cpu_done_d;
  logic              dma_done_q, dma_done_d;
  logic              busy_q, busy_d;

  // Winner selection: the requester not served last wins a tie.
  logic              pick_dma;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  assign pick_dma  = bus.dma_req && (!bus.cpu_req || !last_dma_q);
  assign win_we    = pick_dma ? bus.dma_we    : bus.cpu_we;
  assign win_addr  = pick_dma ? bus.dma_addr  : bus.cpu_addr;
  assign win_wdata = pick_dma ? bus.dma_wdata : bus.cpu_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      own_we_q    <= 1'b0;
      gnt_dma_q   <= 1'b0;
      last_dma_q  <= 1'b1;
      mreq_q      <= 1'b1;
      rd_q        <= 1'b1;
      wr_q        <= 1'b1;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      oe_q        <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      cpu_done_q  <= 1'b0;
      dma_done_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      own_we_q    <= own_we_d;
      gnt_dma_q   <= gnt_dma_d;
      last_dma_q  <= last_dma_d;
      mreq_q      <= mreq_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      oe_q        <= oe_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
      cpu_done_q  <= cpu_done_d;
      dma_done_q  <= dma_done_d;
      busy_q      <= busy_d;
    end
  end

  // Next state plus look-ahead output values, so each registered output lines up with its state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    own_we_d    = own_we_q;
    gnt_dma_d   = gnt_dma_q;
    last_dma_d  = last_dma_q;
    mreq_d      = mreq_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    oe_d        = oe_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    cpu_done_d  = 1'b0;
    dma_done_d  = 1'b0;
    busy_d      = busy_q;

    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (bus.cpu_req || bus.dma_req) begin
          state_d    = ADDR;
          cnt_d      = '0;
          gnt_dma_d  = pick_dma;
          own_we_d   = win_we;
          mem_addr_d = win_addr;
          mreq_d     = 1'b0;
          busy_d     = 1'b1;
          if (win_we) begin
            mem_wdata_d = win_wdata;
            oe_d        = 1'b1;
          end
        end
      end
      ADDR: begin
        state_d = ACCESS;
        rd_d    = own_we_q;
        wr_d    = !own_we_q;
      end
      ACCESS: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = FINISH;
          mreq_d  = 1'b1;
          rd_d    = 1'b1;
          wr_d    = 1'b1;
          oe_d    = 1'b0;
          if (gnt_dma_q) dma_done_d = 1'b1;
          else           cpu_done_d = 1'b1;
          if (!own_we_q) begin
            if (gnt_dma_q) dma_rdata_d = bus.mem_rdata;
            else           cpu_rdata_d = bus.mem_rdata;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FINISH: begin
        state_d    = IDLE;
        busy_d     = 1'b0;
        last_dma_d = gnt_dma_q;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.MREQ_L       = mreq_q;
  assign bus.RD_L         = rd_q;
  assign bus.WR_L         = wr_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.mem_wdata_oe = oe_q;
  assign bus.cpu_rdata    = cpu_rdata_q;
  assign bus.dma_rdata    = dma_rdata_q;
  assign bus.cpu_done     = cpu_done_q;
  assign bus.dma_done     = dma_done_q;
  assign bus.busy         = busy_q;
  assign bus.gnt_dma      = gnt_dma_q;
endmodule

// File: doc/z80_mem_arbiter.md
Name: z80_mem_arbiter

Overview:
- Sequences and shares the single Z80 memory port (MREQ_L/RD_L/WR_L, 16-bit address, 8-bit data) between two requesters: the CPU core and a DMA/boot loader.
- Each requester sees a simple req/done handshake. The arbiter performs a fixed-timing bus cycle (address phase, strobe phase with programmable wait, finish) and returns read data.
- Sits between the CPU/DMA front ends and the memory array. It is the only driver of the memory control strobes.

Parameters:
- ADDR_W, 16, address width
- DATA_W, 8, data width
- WAIT_CYCLES, 1, extra strobe cycles in the ACCESS phase (0..15)

Ports:
- clk  in  1  system clock, all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU requests an access; held until cpu_done
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req high
- cpu_addr  in  ADDR_W  CPU access address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  read data returned to CPU
- cpu_done  out  1  one-cycle completion pulse to CPU
- dma_req, dma_we, dma_addr, dma_wdata, dma_rdata, dma_done  as the cpu_* ports, for the DMA requester
- MREQ_L  out  1  memory request strobe, active-low
- RD_L  out  1  read strobe, active-low
- WR_L  out  1  write strobe, active-low
- mem_addr  out  ADDR_W  address to memory
- mem_wdata  out  DATA_W  write data to memory
- mem_wdata_oe  out  1  1 = drive mem_wdata onto the data bus
- mem_rdata  in  DATA_W  data returned by memory
- busy  out  1  high in any state other than IDLE
- gnt_dma  out  1  owner of the current or last cycle: 0 = CPU, 1 = DMA

Behaviour:
- Reset (async, any state): state=IDLE; MREQ_L=RD_L=WR_L=1; mem_addr=0; mem_wdata=0; mem_wdata_oe=0; cpu_rdata=dma_rdata=0; cpu_done=dma_done=0; busy=0; gnt_dma=0; last_served=DMA, so the CPU wins the first tie.
- FSM states: IDLE -> ADDR -> ACCESS -> FINISH -> IDLE.
- IDLE: on each posedge, sample the two req lines.
  - Only one high: grant it.
  - Both high: grant the requester that is not last_served (round-robin).
  - On grant: latch the winner's we, addr and wdata into the owner registers; set gnt_dma; go to ADDR.
- ADDR (1 cycle):
  - MREQ_L=0, mem_addr=latched addr.
  - For writes: mem_wdata=latched wdata, mem_wdata_oe=1.
  - RD_L and WR_L stay high.
- ACCESS (WAIT_CYCLES+1 cycles, counted by a 4-bit counter):
  - MREQ_L=0; RD_L=0 for reads, WR_L=0 for writes. Address and data stay stable.
  - For reads, latch mem_rdata into the owner's rdata register on the final ACCESS posedge.
- FINISH (1 cycle):
  - All strobes are 1 and mem_wdata_oe=0; mem_addr holds its value.
  - The owner's done=1 and the other requester's done=0.
  - Update last_served to the owner, then go to IDLE.
- Latency: if req is sampled at edge e0, done is high for the cycle starting at edge e0+WAIT_CYCLES+2. A back-to-back grant is sampled earliest at edge e0+WAIT_CYCLES+4.
- Requester protocol:
  - Requester drops req after seeing done. If req is still high in the IDLE cycle after FINISH, it is a new request.
  - Dropping req mid-cycle does not abort the cycle; it completes and done still pulses.
  - Changing we/addr/wdata mid-cycle has no effect, because they were latched at grant.
- Read data: rdata holds its value until that requester's next read completes. Write cycles do not alter rdata.
- Strobe invariant: RD_L and WR_L are never low simultaneously. Neither is low while MREQ_L is high.
- All outputs are registered (no combinational req->strobe paths).
- Reset mid-cycle: strobes deassert immediately and asynchronously; no done is issued. Requesters re-request after reset.

Test Plan:
- Assert rst for 3 cycles mid-ACCESS of a CPU write -> WR_L and MREQ_L go to 1 asynchronously before the next clk edge; all outputs at reset values; no cpu_done pulse.
- CPU read of 0x0001, memory returns 0xA0, WAIT_CYCLES=1 -> MREQ_L low at e0+1..e0+3, RD_L low at e0+2..e0+3, cpu_rdata=0xA0 and cpu_done=1 in the cycle starting at e0+3, WR_L stays 1.
- DMA write of 0x5A to 0x0100 -> mem_addr=0x0100, mem_wdata=0x5A, mem_wdata_oe=1 from ADDR through ACCESS, WR_L low for 2 cycles, dma_done pulses once, gnt_dma=1, cpu_rdata unchanged.
- CPU and DMA requests held high together for 4 transactions -> grant order CPU, DMA, CPU, DMA; each done pulses exactly once per transaction; busy stays high except the single IDLE cycle between transactions.
- WAIT_CYCLES=0 build, CPU read -> RD_L low for exactly 1 cycle, cpu_done in the cycle starting at e0+2.
- CPU drops cpu_req and flips cpu_addr during ACCESS -> the cycle completes to the original address and cpu_done still pulses; no second cycle starts.
